pmux_resp_checker: RTL
======================

# pmux_resp_checker

Synthesizable response checker for the 1-select `$pmux`/`$mux` test cell, `Y = S ? B : A`. It sits on the observing side of the cell harness, opposite the stimulus driver. It samples every A/B/S/Y vector the driver applies and compares Y against the reference function. It keeps counters, a sticky first-failure record and an input-combination coverage map, and gives a final verdict when the driver signals end of test.

## Interface
- `WIDTH`, default 2: data width of A, B, Y; legal range 1..4.
- `CNT_W`, default 16: width of the sample and error counters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `smp_valid` in 1: when high, the current a/b/s/y form one sample.
- `a` in WIDTH: cell input A, as driven.
- `b` in WIDTH: cell input B, as driven.
- `s` in 1: cell select S.
- `y` in WIDTH: observed cell output Y.
- `done` in 1: end-of-test pulse from the driver.
- `smp_cnt` out CNT_W: number of accepted samples, saturating.
- `err_cnt` out CNT_W: number of mismatching samples, saturating.
- `first_err` out 3*WIDTH+1: {s, a, b, y} of the first mismatch; 0 until one occurs.
- `cov_map` out 2^(2*WIDTH+1): one bit per {s, a, b} combination seen.
- `cov_full` out 1: all `cov_map` bits are set.
- `busy` out 1: state is RUN or FAIL.
- `pass` out 1: verdict, valid in DONE.
- `fail` out 1: verdict, valid in DONE.

## Operation
- **Reference function:** `exp = s ? b : a`. A mismatch is `y != exp`. Compare the full WIDTH, no masking.
- **States:** IDLE, RUN, FAIL, DONE.
  - IDLE -> RUN on the first `smp_valid` with no mismatch.
  - IDLE -> FAIL on the first `smp_valid` with a mismatch.
  - RUN -> FAIL on any accepted mismatching sample.
  - RUN -> DONE and FAIL -> DONE on `done`.
  - IDLE -> DONE on `done` with zero samples; the verdict is then `fail`.
  - DONE is terminal until `rst`.
- **Accepted sample:** `smp_valid` high in IDLE, RUN or FAIL.
  - `smp_cnt` increments.
  - `cov_map[{s,a,b}]` is set.
  - On a mismatch, `err_cnt` increments.
  - On a mismatch while `err_cnt == 0`, `first_err <= {s,a,b,y}`; it is never overwritten afterwards.
- **In DONE:** `smp_valid` is ignored and all counters, the map and `first_err` are frozen.
- **Simultaneous `smp_valid` and `done` in the same cycle:** the sample is accepted first (counted, checked, covered), then the state moves to DONE. A mismatch in that sample yields `fail`.
- **Saturation:** both counters stop at 2^CNT_W-1. `err_cnt` saturating does not clear the FAIL status.
- **Verdict in DONE:**
  - `pass = (err_cnt == 0) && (smp_cnt != 0) && cov_full`.
  - `fail = !pass`.
  - Outside DONE, both `pass` and `fail` are 0.
- **Reset values:** state IDLE; `smp_cnt`, `err_cnt`, `first_err` and `cov_map` all 0; `cov_full`, `busy`, `pass` and `fail` all 0.

## Timing
- Inputs are sampled at rising edge N. Counters, the map, `first_err` and the state update at N, so the results are visible in the cycle after N.
- `cov_full` is derived combinationally from the registered `cov_map`: it rises in the cycle after the last missing combination is sampled.
- `pass`/`fail` are a combinational decode of state DONE plus registered values. They become valid in the cycle after the `done` edge.
- `rst` high at an edge overrides every other input, including `smp_valid` and `done` in the same cycle. Asserting `rst` mid-run returns the block to IDLE with everything cleared.
- `done` is edge-insensitive: a multi-cycle `done` level behaves the same as a one-cycle pulse.
- There is no back-pressure; the checker accepts one sample per cycle indefinitely.

## Structure
- **Package `pmux_chk_pkg`:**
  - the state enum `chk_state_t` {IDLE, RUN, FAIL, DONE};
  - function `cov_bits(width) = 2**(2*width+1)`;
  - the packing order constant for `first_err` ({s,a,b,y}, MSB first).
- **Sub-module `sat_counter`:** parameter W; ports clk, rst, inc, q; saturating. It is instantiated twice, for `smp_cnt` and `err_cnt`.
- The state register, compare logic, coverage map and first-error capture stay in the top module.

## Test plan
- **Exhaustive correct pass:** WIDTH=2. Drive all 32 {s,a,b} combinations with a correct y (e.g. s=1, a=01, b=10 -> y=10), then pulse `done`. Expect `smp_cnt=32`, `err_cnt=0`, `cov_full=1`, `pass=1`.
- **Single corrupted sample:** same sequence, but sample s=0, a=11, b=00 is driven with y=00. Expect `err_cnt=1`, `first_err={0,11,00,00}`, state FAIL until `done`, then `fail=1`.
- **First error is sticky:** two mismatches, first {1,01,10,01} then {0,10,11,11}. Expect `err_cnt=2` and `first_err` still equal to the first record.
- **Incomplete coverage:** only the s=1 half is driven, all correct. Expect `cov_full=0` and, after `done`, `fail=1` with `err_cnt=0`.
- **Boundary events:** a mismatching sample together with `done` in one cycle gives `err_cnt=1` and `fail=1`. A further `smp_valid` in DONE leaves `smp_cnt` unchanged. `rst` in the same cycle as `smp_valid` leaves all outputs at 0 and the state IDLE.
- **Saturation:** CNT_W=3, drive 10 mismatches. Expect `err_cnt=7`, `smp_cnt=7`, and `fail=1` after `done`.

Source files
------------

// File: rtl/pmux_chk_pkg.sv
// Shared types and sizing helpers for the 1-select pmux response checker.
// Defines the checker state encoding, the coverage-map size and the first-error field layout.
package pmux_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAIL = 2'd2,
        DONE = 2'd3
    } chk_state_t;

    // Field order of the first-error record {s, a, b, y}, MSB first; y sits at bit 0.
    typedef enum int {
        FE_Y = 0,
        FE_B = 1,
        FE_A = 2,
        FE_S = 3
    } fe_field_t;

    function automatic int cov_bits(input int width);
        return 2 ** (2 * width + 1);
    endfunction

    function automatic int fe_lsb(input int width, input fe_field_t f);
        return int'(f) * width;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
// Used for both the sample and the error counts.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/pmux_resp_checker.sv
// Observing-side checker for the Y = S ? B : A test cell: counts samples and errors,
// records the first mismatch, tracks {s,a,b} coverage and issues a verdict at end of test.
module pmux_resp_checker
    import pmux_chk_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         smp_valid,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         s,
    input  logic [WIDTH-1:0]             y,
    input  logic                         done,
    output logic [CNT_W-1:0]             smp_cnt,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [3*WIDTH:0]             first_err,
    output logic [cov_bits(WIDTH)-1:0]   cov_map,
    output logic                         cov_full,
    output logic                         busy,
    output logic                         pass,
    output logic                         fail
);

    localparam int COV_N    = cov_bits(WIDTH);
    localparam int FE_Y_LSB = fe_lsb(WIDTH, FE_Y);
    localparam int FE_B_LSB = fe_lsb(WIDTH, FE_B);
    localparam int FE_A_LSB = fe_lsb(WIDTH, FE_A);
    localparam int FE_S_LSB = fe_lsb(WIDTH, FE_S);

    chk_state_t             r_state;
    chk_state_t             w_state_nxt;
    logic                   w_acc;
    logic                   w_mis;
    logic [WIDTH-1:0]       w_exp;
    logic [2*WIDTH:0]       w_idx;
    logic [3*WIDTH:0]       w_rec;
    logic [3*WIDTH:0]       r_first_err;
    logic [COV_N-1:0]       r_cov_map;

    assign w_acc = smp_valid && (r_state != DONE);
    assign w_exp = s ? b : a;
    assign w_mis = w_acc && (y != w_exp);
    assign w_idx = {s, a, b};

    always_comb begin
        w_rec                         = '0;
        w_rec[FE_Y_LSB +: WIDTH]      = y;
        w_rec[FE_B_LSB +: WIDTH]      = b;
        w_rec[FE_A_LSB +: WIDTH]      = a;
        w_rec[FE_S_LSB]               = s;
    end

    sat_counter #(.W(CNT_W)) u_smp_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_acc),
        .q   (smp_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_mis),
        .q   (err_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // A sample arriving with done is still accepted; done only decides where we go next.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (done)
                    w_state_nxt = DONE;
                else if (smp_valid)
                    w_state_nxt = w_mis ? FAIL : RUN;
            end
            RUN: begin
                if (done)
                    w_state_nxt = DONE;
                else if (w_mis)
                    w_state_nxt = FAIL;
            end
            FAIL: begin
                if (done)
                    w_state_nxt = DONE;
            end
            default: w_state_nxt = DONE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        pass = 1'b0;
        fail = 1'b0;
        case (r_state)
            RUN, FAIL: busy = 1'b1;
            DONE: begin
                pass = (err_cnt == '0) && (smp_cnt != '0) && cov_full;
                fail = !pass;
            end
            default: ;
        endcase
    end

    // err_cnt is zero only before the first mismatch, so this capture happens once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_err <= '0;
            r_cov_map   <= '0;
        end else begin
            if (w_mis && (err_cnt == '0))
                r_first_err <= w_rec;
            if (w_acc)
                r_cov_map[w_idx] <= 1'b1;
        end
    end

    assign first_err = r_first_err;
    assign cov_map   = r_cov_map;
    assign cov_full  = &r_cov_map;

endmodule
